mem_arbiter: RTL

Sequential arbiter sharing the single-ported RAM between the instruction-fetch path (iREN) and the data path (dREN/dWEN) driven by the control unit's memory signals. A registered FSM grants one requester at a time, holds the grant across RAM wait states, and returns per-requester wait signals to the datapath. Data has priority, with a starvation limit that guarantees instruction fetch forward progress.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and RAM buses that meet at the memory arbiter.
// Latency: none, this file only declares wires.
// Backpressure: iwait/dwait return the wait state to each requester.
interface mem_arbiter_if;
  // instruction fetch side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // data side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  // arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // requester / RAM view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data, data first with a starvation cap.
// Latency: 1 arbitration cycle plus RAM wait states; one IDLE bubble after each completion.
// Backpressure: grant held while ramstate != ACCESS; requester sees iwait/dwait high until done.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  localparam int             CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  DMAX       = CW'(STARVE_MAX);
  localparam logic [1:0]     RAM_ACCESS = 2'd2;

  state_t        state, next_state;
  logic [CW-1:0] dcnt, dcnt_next;

  logic        dreq;
  logic        access;
  logic        icomp;
  logic        dcomp;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        i_wait;
  logic        d_wait;

  assign dreq   = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == RAM_ACCESS);
  // a completion only counts while the request is still live; otherwise it is an abort
  assign icomp  = (state == IGRANT) && access && bus.iREN;
  assign dcomp  = (state == DGRANT) && access && dreq;

  // state and starvation counter registers; reset forces IDLE at once
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= next_state;
      dcnt  <= dcnt_next;
    end
  end

  // arbitration, RAM drive and wait outputs; enables track the live request so aborts drop them
  always_comb begin
    next_state = state;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_store  = '0;
    i_wait     = 1'b1;
    d_wait     = 1'b1;
    case (state)
      IDLE: begin
        if (dreq && bus.iREN && (dcnt == DMAX)) next_state = IGRANT;
        else if (dreq)                          next_state = DGRANT;
        else if (bus.iREN)                      next_state = IGRANT;
      end
      IGRANT: begin
        ram_ren  = bus.iREN;
        ram_addr = bus.iaddr;
        if (access) i_wait = 1'b0;
        if (!bus.iREN || access) next_state = IDLE;
      end
      DGRANT: begin
        ram_addr = bus.daddr;
        if (bus.dWEN) begin
          ram_wen   = 1'b1;
          ram_store = bus.dstore;
        end else begin
          ram_ren = bus.dREN;
        end
        if (access) d_wait = 1'b0;
        if (!dreq || access) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // starvation count: data wins while fetch waits, saturating; fetch or an idle fetch side clears it
  always_comb begin
    dcnt_next = dcnt;
    if (icomp) begin
      dcnt_next = '0;
    end else if (dcomp) begin
      if (!bus.iREN)         dcnt_next = '0;
      else if (dcnt != DMAX) dcnt_next = dcnt + 1'b1;
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = i_wait;
  assign bus.dwait    = d_wait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

endmodule
